// File: rtl/mx_pkg.sv
// Shared FP32 field layout, E8M0 constants, FSM state type and MX format helpers.
// The LFSR constants are used only when MX_STOCH_ROUND_EN is defined.
package mx_pkg;

  localparam int FP32_MAN_W    = 23;
  localparam int FP32_EXP_W    = 8;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_SIGN_BIT = 31;

  localparam logic [7:0] E8M0_NAN = 8'hFF;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

  // Largest unbiased element exponent; the format reserves no Inf/NaN codes
  function automatic int mx_emax(input int ebits, input int ebias);
    return ((2 ** ebits) - 1) - ebias;
  endfunction

endpackage

// File: rtl/mx_elem_encode.sv
// Combinational FP32 -> signed E<EBITS>M<MBITS> element under shared scale X.
// RNE by default; MX_STOCH_ROUND_EN switches to stochastic rounding driven by rnd_i.
module mx_elem_encode
  import mx_pkg::*;
#(
  parameter int EBITS = 3,
  parameter int MBITS = 2,
  parameter int EBIAS = 3
) (
  input  logic [31:0]          fp_i,
  input  logic [7:0]           scale_i,
  input  logic [15:0]          rnd_i,
  output logic [EBITS+MBITS:0] elem_o
);

  localparam int W   = EBITS + MBITS;
  localparam int SHN = FP32_MAN_W - MBITS;
  localparam logic [47:0]        MAXCODE     = 48'((1 << W) - 1);
  localparam logic [47:0]        HIDDEN      = 48'(1 << MBITS);
  // Shifts this deep leave the value under half the smallest subnormal
  localparam logic signed [10:0] DEPTH_FLUSH = 11'(MBITS + 2);

  logic                sgn;
  logic [7:0]          ex;
  logic signed [10:0]  field;
  logic signed [10:0]  depth;
  logic                sub;
  logic                flush;
  logic                up;
  logic [5:0]          sh;
  logic [47:0]         sig_w;
  logic [47:0]         q0;
  logic [47:0]         one_sh;
  logic [47:0]         rem;
  logic [47:0]         q;
  logic [47:0]         code;

`ifndef MX_STOCH_ROUND_EN
  logic unused_rnd;
  assign unused_rnd = ^rnd_i;
`endif

  always_comb begin
    sgn    = fp_i[FP32_SIGN_BIT];
    ex     = fp_i[FP32_EXP_LSB +: FP32_EXP_W];
    sig_w  = 48'({1'b1, fp_i[FP32_MAN_W-1:0]});
    field  = 11'(ex) - 11'(scale_i) + 11'(EBIAS);
    depth  = 11'sd1 - field;
    sub    = (field < 11'sd1);
    flush  = (ex == 8'd0) || (sub && (depth >= DEPTH_FLUSH));
    sh     = sub ? (6'(SHN) + depth[5:0]) : 6'(SHN);

    q0     = sig_w >> sh;
    one_sh = 48'd1 << sh;
    rem    = sig_w & (one_sh - 48'd1);
`ifdef MX_STOCH_ROUND_EN
    // LFSR bits sit at the top of the discarded field
    up     = (rem + (48'(rnd_i) << (sh - 6'd16))) >= one_sh;
`else
    up     = (rem > (one_sh >> 1)) || ((rem == (one_sh >> 1)) && q0[0]);
`endif
    q      = q0 + 48'(up);

    // {exp,mant} read as one integer lets mantissa carry ripple into the exponent
    if (sub) code = q;
    else     code = (48'(field) << MBITS) + q - HIDDEN;
    if (code > MAXCODE) code = MAXCODE;

    elem_o = {sgn, code[W-1:0]};
    if (flush)                 elem_o = {sgn, {W{1'b0}}};
    if (scale_i == E8M0_NAN)   elem_o = '0;
  end

endmodule

// File: rtl/mx_block_quantizer.sv
// Streaming FP32 -> MX block quantizer: buffer a block, derive the E8M0 scale, emit elements.
// Define MX_STOCH_ROUND_EN for stochastic rounding from a 16-bit Galois LFSR.
//   state | meaning
//   FILL  | accepting FP32 beats, tracking max exponent / NaN
//   CALC  | one cycle to register the shared scale X
//   DRAIN | emitting one encoded element per accepted output
module mx_block_quantizer
  import mx_pkg::*;
#(
  parameter int BLOCK_SIZE = 32,
  parameter int EBITS      = 3,
  parameter int MBITS      = 2,
  parameter int EBIAS      = 3,
  parameter int EMAX       = mx_emax(EBITS, EBIAS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EBITS+MBITS:0]   out_elem,
  output logic [7:0]             out_scale,
  output logic                   out_last
);

  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int EW = 1 + EBITS + MBITS;

  fsm_state_t      state_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   rd_ptr_q;
  logic [7:0]      max_exp_q;
  logic [7:0]      scale_q;
  logic            nan_q;
  logic            issued_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [EW-1:0]   out_elem_q;
  logic [31:0]     buf_q [BLOCK_SIZE];

  logic [7:0]      in_exp;
  logic            in_acc;
  logic            close;
  logic            out_acc;
  logic            load;
  logic [EW-1:0]   enc_elem;
  logic [15:0]     rnd;

  assign in_exp  = in_data[FP32_EXP_LSB +: FP32_EXP_W];
  assign in_acc  = in_valid && in_ready_q;
  assign close   = in_acc && (in_last || (count_q == CW'(BLOCK_SIZE - 1)));
  assign out_acc = out_valid_q && out_ready;
  assign load    = (state_q == DRAIN) && !issued_q && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (in_acc) buf_q[count_q] <= in_data;
  end

`ifdef MX_STOCH_ROUND_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr_q <= LFSR_SEED;
    else if (out_acc) lfsr_q <= lfsr_d;
  end

  // An element loaded on the same edge as an accept must see the advanced value
  assign rnd = out_acc ? lfsr_d : lfsr_q;
`else
  assign rnd = 16'h0000;
`endif

  mx_elem_encode #(
    .EBITS (EBITS),
    .MBITS (MBITS),
    .EBIAS (EBIAS)
  ) u_encode (
    .fp_i    (buf_q[rd_ptr_q]),
    .scale_i (scale_q),
    .rnd_i   (rnd),
    .elem_o  (enc_elem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      count_q     <= '0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      max_exp_q   <= 8'd0;
      scale_q     <= 8'd0;
      nan_q       <= 1'b0;
      issued_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_elem_q  <= '0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_acc) begin
            count_q <= count_q + 1'b1;
            if (in_exp > max_exp_q)  max_exp_q <= in_exp;
            if (in_exp == E8M0_NAN)  nan_q     <= 1'b1;
            if (close) begin
              state_q    <= CALC;
              in_ready_q <= 1'b0;
              len_q      <= count_q;
              count_q    <= '0;
            end
          end
        end
        CALC: begin
          if (nan_q)                       scale_q <= E8M0_NAN;
          else if (max_exp_q >= 8'(EMAX))  scale_q <= max_exp_q - 8'(EMAX);
          else                             scale_q <= 8'd0;
          rd_ptr_q <= '0;
          issued_q <= 1'b0;
          state_q  <= DRAIN;
        end
        DRAIN: begin
          if (load) begin
            out_valid_q <= 1'b1;
            out_elem_q  <= enc_elem;
            out_last_q  <= (rd_ptr_q == len_q);
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            if (rd_ptr_q == len_q) issued_q <= 1'b1;
          end else if (out_acc) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q    <= FILL;
              in_ready_q <= 1'b1;
              max_exp_q  <= 8'd0;
              nan_q      <= 1'b0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_elem  = out_elem_q;
  assign out_scale = scale_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Directed bench for mx_block_quantizer (E3M2 defaults) with hand-computed expectations.
module tb_mx_block_quantizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_elem;
  logic [7:0]  out_scale;
  logic        out_last;

  always #5 clk = ~clk;

  mx_block_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_elem  (out_elem),
    .out_scale (out_scale),
    .out_last  (out_last)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] blk   [64];
  logic [5:0]  exp_e [64];
  logic        chk_elem  = 1'b1;
  longint      stoch_sum = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_const(input int n, input logic [31:0] d, input logic [5:0] e);
    for (int i = 0; i < n; i++) begin
      blk[i]   = d;
      exp_e[i] = e;
    end
  endtask

  task automatic send_block(input int n, input logic early_last);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 300) begin
      @(negedge clk);
      if (in_ready) begin
        in_valid = 1'b1;
        in_data  = blk[i];
        in_last  = early_last && (i == n - 1);
        i++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (i < n) check_eq("send_timeout", i, n);
  endtask

  task automatic drain(input int n, input logic [7:0] xs, input logic toggle, input logic chk_lat);
    int idx = 0;
    int k = 0;
    int first_k = -1;
    while (idx < n && k < 400) begin
      out_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (out_valid) begin
        if (first_k < 0) first_k = k;
        if (out_ready) begin
          if (chk_elem) check_eq($sformatf("elem%0d", idx), out_elem, exp_e[idx]);
          else stoch_sum += longint'((4 + int'(out_elem[1:0])) << out_elem[4:2]);
          check_eq($sformatf("last%0d", idx), out_last, (idx == n - 1));
          check_eq($sformatf("scale%0d", idx), out_scale, xs);
          idx++;
        end else if (chk_elem) begin
          check_eq($sformatf("stall_elem%0d", idx), out_elem, exp_e[idx]);
        end
      end
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    if (idx < n) check_eq("drain_timeout", idx, n);
    if (chk_lat) check_eq("latency", first_k, 2);
    check_eq("no_extra_valid", out_valid, 1'b0);
    check_eq("in_ready_back", in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_elem", out_elem, 6'h00);
    check_eq("rst_out_scale", out_scale, 8'h00);
    check_eq("rst_out_last", out_last, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    // Full block of 1.0 without in_last
    fill_const(32, 32'h3F800000, 6'h1C);
    send_block(32, 1'b0);
    drain(32, 8'd123, 1'b0, 1'b1);

    // Mixed values, closed by in_last on the 32nd beat
    fill_const(32, 32'h00000000, 6'h00);
    blk[0] = 32'h3FE00000; exp_e[0] = 6'h1F;
    blk[1] = 32'h3F000000; exp_e[1] = 6'h18;
    blk[2] = 32'h3F900000; exp_e[2] = 6'h1C;
    blk[3] = 32'h3FB00000; exp_e[3] = 6'h1E;
    blk[4] = 32'hBF800000; exp_e[4] = 6'h3C;
    blk[5] = 32'h35800000; exp_e[5] = 6'h00;
    send_block(32, 1'b1);
    drain(32, 8'd123, 1'b0, 1'b0);

    // Partial block of 5, max exponent 128 -> X=124
    blk[0] = 32'h40000000; exp_e[0] = 6'h1C;
    blk[1] = 32'h3F800000; exp_e[1] = 6'h18;
    blk[2] = 32'h3E800000; exp_e[2] = 6'h10;
    blk[3] = 32'h40400000; exp_e[3] = 6'h1E;
    blk[4] = 32'hBF400000; exp_e[4] = 6'h36;
    send_block(5, 1'b1);
    drain(5, 8'd124, 1'b0, 1'b0);

    // NaN forces X=FF and zero elements
    fill_const(4, 32'h3F800000, 6'h00);
    blk[1] = 32'h7FC00000;
    blk[2] = 32'h40000000;
    blk[3] = 32'hBF800000;
    send_block(4, 1'b1);
    drain(4, 8'hFF, 1'b0, 1'b0);

    // Saturation, subnormals, ties, flush, signed zero; stalled every other cycle
    blk[0] = 32'h3FF80000; exp_e[0] = 6'h1F;
    blk[1] = 32'h3C000000; exp_e[1] = 6'h02;
    blk[2] = 32'h3B800000; exp_e[2] = 6'h01;
    blk[3] = 32'h3B000000; exp_e[3] = 6'h00;
    blk[4] = 32'h3B400000; exp_e[4] = 6'h01;
    blk[5] = 32'h3AC00000; exp_e[5] = 6'h00;
    blk[6] = 32'hBBC00000; exp_e[6] = 6'h22;
    blk[7] = 32'h3C700000; exp_e[7] = 6'h04;
    blk[8] = 32'h80000000; exp_e[8] = 6'h20;
    blk[9] = 32'h00000001; exp_e[9] = 6'h00;
    send_block(10, 1'b1);
    drain(10, 8'd123, 1'b1, 1'b0);

    // Reset after 10 large beats; the next block must not see them
    fill_const(10, 32'h44800000, 6'h00);
    send_block(10, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_out_scale", out_scale, 8'h00);
    check_eq("mid_rst_out_last", out_last, 1'b0);
    check_eq("mid_rst_out_elem", out_elem, 6'h00);
    @(negedge clk);
    rst_n = 1'b1;
    fill_const(32, 32'h3F000000, 6'h1C);
    send_block(32, 1'b0);
    drain(32, 8'd122, 1'b0, 1'b0);

`ifdef MX_STOCH_ROUND_EN
    chk_elem  = 1'b0;
    stoch_sum = 0;
    for (int b = 0; b < 32; b++) begin
      fill_const(32, 32'h3F900000, 6'h00);
      send_block(32, 1'b0);
      drain(32, 8'd123, 1'b0, 1'b0);
    end
    // Mean of 18 over 1024 elements in units of 1/32, tolerance 0.2
    check_eq("stoch_mean",
             (stoch_sum >= longint'(32 * (18 * 1024 - 205))) &&
             (stoch_sum <= longint'(32 * (18 * 1024 + 205))), 1'b1);
    chk_elem = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
